ring_mem_requester: RTL and testbench

Ring-side memory initiator for a core/cache: accepts one 128-bit line read or write from a local client, waits for the ring token, injects an `Address` slot (plus four `WriteData` slots for writes) onto the ring, and collects the four-word read return from the separate RD return path. It is the counterpart of the ring memory controller. It sits in the ring chain as a registered pass-through node and removes its own messages when they come back around.

---
 rtl/ring_mem_requester.sv | 161 ++++++++++++++++
 tb/tb_ring_mem_requester.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_mem_requester.sv
// Ring-side memory initiator: injects line reads/writes on the token
// and collects the four-word read return from the RD path.
module ring_mem_requester #(
  parameter logic [3:0] MY_ID = 4'd1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  RingIn,
  input  logic [3:0]   SlotTypeIn,
  input  logic [3:0]   SourceIn,
  output logic [31:0]  RingOut,
  output logic [3:0]   SlotTypeOut,
  output logic [3:0]   SourceOut,
  input  logic [31:0]  RDreturn,
  input  logic [3:0]   RDdest,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic         reqRead,
  input  logic [25:0]  reqAddr,
  input  logic [127:0] reqWdata,
  output logic [127:0] rdData,
  output logic         rdValid,
  output logic         busy
);

  localparam logic [3:0] T_NULL  = 4'd0;
  localparam logic [3:0] T_TOKEN = 4'd1;
  localparam logic [3:0] T_ADDR  = 4'd2;
  localparam logic [3:0] T_WDATA = 4'd3;

  typedef enum logic [1:0] {
    S_PASS,
    S_WR,
    S_TOK,
    S_WAITRD
  } state_t;

  state_t         state_q;
  logic           pend_q;
  logic           rdout_q;
  logic [1:0]     wcnt_q;
  logic [1:0]     rcnt_q;
  logic [31:0]    ring_q;
  logic [3:0]     type_q;
  logic [3:0]     src_q;
  logic           rdvalid_q;
  logic [127:0]   rddata_q;
  logic [95:0]    rbuf_q;
  logic           req_rd_q;
  logic [25:0]    addr_q;
  logic [127:0]   wdata_q;

  logic           accept;
  logic           my_ret;
  logic [31:0]    addr_word;
  logic [31:0]    wr_word;

  assign reqReady  = (state_q == S_PASS) & ~pend_q & ~rdout_q;
  assign accept    = reqValid & reqReady;
  assign my_ret    = (RDdest == MY_ID) & rdout_q;
  assign addr_word = {3'b000, req_rd_q, 2'b00, addr_q};
  assign wr_word   = wdata_q[{wcnt_q, 5'd0} +: 32];

  assign RingOut     = ring_q;
  assign SlotTypeOut = type_q;
  assign SourceOut   = src_q;
  assign rdData      = rddata_q;
  assign rdValid     = rdvalid_q;
  assign busy        = pend_q | (state_q != S_PASS) | rdout_q;

  // Capture the client request when it is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_rd_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      req_rd_q <= reqRead;
      addr_q   <= reqAddr;
      wdata_q  <= reqWdata;
    end
  end

  // Ring node FSM, registered ring outputs and read-return collection.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_PASS;
      pend_q    <= 1'b0;
      rdout_q   <= 1'b0;
      wcnt_q    <= 2'd0;
      rcnt_q    <= 2'd0;
      ring_q    <= '0;
      type_q    <= T_NULL;
      src_q     <= '0;
      rdvalid_q <= 1'b0;
      rddata_q  <= '0;
      rbuf_q    <= '0;
    end else begin
      rdvalid_q <= 1'b0;
      if (accept) begin
        pend_q <= 1'b1;
      end
      if (my_ret) begin
        if (rcnt_q == 2'd3) begin
          rddata_q  <= {RDreturn, rbuf_q};
          rdvalid_q <= 1'b1;
          rdout_q   <= 1'b0;
          rcnt_q    <= 2'd0;
        end else begin
          rbuf_q[{rcnt_q, 5'd0} +: 32] <= RDreturn;
          rcnt_q <= rcnt_q + 2'd1;
        end
      end
      unique case (state_q)
        S_PASS, S_WAITRD: begin
          type_q <= SlotTypeIn;
          ring_q <= RingIn;
          src_q  <= SourceIn;
          if (SourceIn == MY_ID && SlotTypeIn != T_TOKEN) begin
            type_q <= T_NULL;
            ring_q <= '0;
            src_q  <= '0;
          end
          if (state_q == S_PASS && SlotTypeIn == T_TOKEN
              && pend_q) begin
            type_q <= T_ADDR;
            ring_q <= addr_word;
            src_q  <= MY_ID;
            pend_q <= 1'b0;
            if (req_rd_q) begin
              rdout_q <= 1'b1;
              state_q <= S_TOK;
            end else begin
              wcnt_q  <= 2'd0;
              state_q <= S_WR;
            end
          end
          if (state_q == S_WAITRD && rdvalid_q) begin
            state_q <= S_PASS;
          end
        end
        S_WR: begin
          type_q <= T_WDATA;
          ring_q <= wr_word;
          src_q  <= MY_ID;
          wcnt_q <= wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_q <= S_TOK;
          end
        end
        S_TOK: begin
          type_q  <= T_TOKEN;
          ring_q  <= '0;
          src_q   <= '0;
          state_q <= rdout_q ? S_WAITRD : S_PASS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_mem_requester.sv
// Scoreboard bench for ring_mem_requester: a slot-queue model predicts
// every output cycle; a monitor pops and compares after each edge.
module tb_ring_mem_requester;

  localparam logic [3:0] MY    = 4'd1;
  localparam logic [3:0] TNULL = 4'd0;
  localparam logic [3:0] TTOK  = 4'd1;
  localparam logic [3:0] TADDR = 4'd2;
  localparam logic [3:0] TWD   = 4'd3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  RingIn = '0;
  logic [3:0]   SlotTypeIn = '0;
  logic [3:0]   SourceIn = '0;
  logic [31:0]  RingOut;
  logic [3:0]   SlotTypeOut;
  logic [3:0]   SourceOut;
  logic [31:0]  RDreturn = '0;
  logic [3:0]   RDdest = '0;
  logic         reqValid = 1'b0;
  logic         reqReady;
  logic         reqRead = 1'b0;
  logic [25:0]  reqAddr = '0;
  logic [127:0] reqWdata = '0;
  logic [127:0] rdData;
  logic         rdValid;
  logic         busy;

  always #5 clock = ~clock;

  ring_mem_requester #(.MY_ID(MY)) dut (
    .clock(clock), .reset(reset),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn),
    .SourceIn(SourceIn), .RingOut(RingOut),
    .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqRead(reqRead), .reqAddr(reqAddr),
    .reqWdata(reqWdata), .rdData(rdData),
    .rdValid(rdValid), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]  t;
    logic [31:0] d;
    logic [3:0]  s;
  } slot_t;

  typedef struct packed {
    slot_t        o;
    logic         rdy;
    logic         bsy;
    logic         rdv;
    logic [127:0] rdd;
  } exp_t;

  exp_t         exp_q[$];
  slot_t        hold[$];
  logic [31:0]  m_words[$];
  bit           m_pend = 0;
  bit           m_rd = 0;
  logic [25:0]  m_addr = '0;
  logic [127:0] m_wd = '0;
  logic [127:0] m_line = '0;
  int           m_phase = 0;
  int           checks = 0;
  int           errors = 0;

  function automatic bit m_ready();
    return hold.size() == 0 && !m_pend && m_phase == 0;
  endfunction

  // Predict the outputs seen after the next edge from this cycle's inputs.
  task automatic model_step(
    input logic         rst,
    input slot_t        in,
    input logic [3:0]   rdd,
    input logic [31:0]  rdw,
    input bit           acc,
    input bit           rrd,
    input logic [25:0]  ra,
    input logic [127:0] rw
  );
    exp_t  e;
    slot_t o;
    int    oldp;
    e = '0;
    if (rst) begin
      hold.delete();
      m_words.delete();
      m_pend  = 0;
      m_phase = 0;
      m_line  = '0;
      e.o   = '{TNULL, 32'd0, 4'd0};
      e.rdy = 1'b1;
      exp_q.push_back(e);
      return;
    end
    oldp = m_phase;
    if (hold.size() != 0) begin
      o = hold.pop_front();
    end else if (in.t == TTOK && m_pend) begin
      hold.push_back('{TADDR, {3'b000, m_rd, 2'b00, m_addr}, MY});
      if (!m_rd)
        for (int k = 0; k < 4; k++)
          hold.push_back('{TWD, m_wd[32*k +: 32], MY});
      hold.push_back('{TTOK, 32'd0, 4'd0});
      o = hold.pop_front();
      m_pend = 0;
      if (m_rd) m_phase = 1;
    end else if (in.s == MY && in.t != TTOK) begin
      o = '{TNULL, 32'd0, 4'd0};
    end else begin
      o = in;
    end
    if (oldp == 1 && rdd == MY) begin
      m_words.push_back(rdw);
      if (m_words.size() == 4) begin
        m_line = {m_words[3], m_words[2], m_words[1], m_words[0]};
        m_words.delete();
        m_phase = 2;
        e.rdv = 1'b1;
      end
    end else if (oldp == 2) begin
      m_phase = 0;
    end
    if (acc) begin
      m_pend = 1;
      m_rd   = rrd;
      m_addr = ra;
      m_wd   = rw;
    end
    e.o   = o;
    e.rdy = m_ready();
    e.bsy = m_pend || hold.size() != 0 || m_phase != 0;
    e.rdd = m_line;
    exp_q.push_back(e);
  endtask

  task automatic cyc(
    input logic         rst,
    input logic [3:0]   t,
    input logic [31:0]  d,
    input logic [3:0]   s,
    input logic [3:0]   rdd,
    input logic [31:0]  rdw,
    input logic         rv,
    input logic         rrd,
    input logic [25:0]  ra,
    input logic [127:0] rw
  );
    bit acc;
    @(negedge clock);
    acc = rv && !rst && m_ready();
    reset      = rst;
    SlotTypeIn = t;
    RingIn     = d;
    SourceIn   = s;
    RDdest     = rdd;
    RDreturn   = rdw;
    reqValid   = rv;
    reqRead    = rrd;
    reqAddr    = ra;
    reqWdata   = rw;
    model_step(rst, '{t, d, s}, rdd, rdw, acc, rrd, ra, rw);
  endtask

  task automatic ring(input logic [3:0] t, input logic [31:0] d,
                      input logic [3:0] s);
    cyc(1'b0, t, d, s, 4'd0, 32'd0, 1'b0, 1'b0, 26'd0, 128'd0);
  endtask

  task automatic nulls(input int n);
    for (int i = 0; i < n; i++) ring(TNULL, 32'd0, 4'd0);
  endtask

  task automatic req(input logic rd, input logic [25:0] a,
                     input logic [127:0] w, input logic [3:0] t);
    cyc(1'b0, t, 32'd0, 4'd0, 4'd0, 32'd0, 1'b1, rd, a, w);
  endtask

  task automatic ret(input logic [31:0] w);
    cyc(1'b0, TNULL, 32'd0, 4'd0, MY, w, 1'b0, 1'b0, 26'd0, 128'd0);
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h",
               name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ring", {88'd0, SlotTypeOut, RingOut, SourceOut}, 128'(e.o));
        chk("reqReady", 128'(reqReady), 128'(e.rdy));
        chk("busy", 128'(busy), 128'(e.bsy));
        chk("rdValid", 128'(rdValid), 128'(e.rdv));
        chk("rdData", rdData, e.rdd);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    logic [3:0]  t;
    logic [3:0]  rdd;
    int          r;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, TNULL, 32'd0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 26'd0, 128'd0);
    ring(TADDR, 32'h12345678, 4'd3);
    ring(TTOK, 32'd0, 4'd0);
    nulls(2);
    req(1'b0, 26'h0000040,
        128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, TNULL);
    nulls(2);
    ring(TTOK, 32'd0, 4'd0);
    nulls(7);
    req(1'b1, 26'h3FFFFFF, 128'd0, TNULL);
    nulls(1);
    ring(TTOK, 32'd0, 4'd0);
    nulls(3);
    ret(32'hAAAA0001);
    nulls(1);
    ret(32'hBBBB0002);
    nulls(2);
    ret(32'hCCCC0003);
    ret(32'hDDDD0004);
    nulls(3);
    ring(TADDR, 32'hDEADBEEF, MY);
    ring(TWD, 32'h01020304, MY);
    ring(TTOK, 32'd0, MY);
    ret(32'h55555555);
    nulls(2);
    req(1'b0, 26'h0000123,
        128'h44444444_33333333_22222222_11111111, TTOK);
    nulls(3);
    ring(TTOK, 32'd0, 4'd0);
    nulls(7);
    req(1'b0, 26'h0000055,
        128'h99999999_88888888_77777777_66666666, TNULL);
    nulls(1);
    ring(TTOK, 32'd0, 4'd0);
    nulls(2);
    cyc(1'b1, TNULL, 32'd0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 26'd0, 128'd0);
    nulls(3);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 7));
      t = (r < 4) ? TNULL : (r == 4) ? TTOK : (r == 5) ? TADDR :
          (r == 6) ? TWD : 4'($urandom_range(0, 15));
      rdd = $urandom_range(0, 1) ? MY : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 599) == 0), t, $urandom,
          4'($urandom_range(0, 3)), rdd, $urandom,
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          26'($urandom), {$urandom, $urandom, $urandom, $urandom});
    end
    nulls(1);
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
